pulse_gap_shaper: RTL and testbench
===================================

# pulse_gap_shaper

Single-clock pulse queue and spacer that sits in the TX clock domain directly upstream of the pulse synchronizer. It accepts single-cycle event pulses arriving at any rate, including back-to-back, and counts them as pending. It re-emits them one at a time, at least GAP TX cycles apart. This meets the synchronizer's minimum inter-pulse interval and prevents events from merging or being lost across the clock crossing.

## Interface
- CNT_WIDTH, default 4: width of the pending-event counter; capacity is 2^CNT_WIDTH-1 events.
- GAP, default 4: minimum TX cycles between consecutive out_pulse assertions. Legal range is 2 to 255. The integrator sets it to cover at least 2 RX cycles plus margin.
- tx_clk  input  1  TX domain clock; all logic is on its rising edge.
- tx_rst_b  input  1  asynchronous, active-low reset.
- in_pulse  input  1  event pulse; each high cycle is one event.
- ovf_clr  input  1  clears the sticky overflow flag.
- out_pulse  output  1  registered, single-cycle spaced pulse, fed to the synchronizer's tx_pulse.
- pending  output  CNT_WIDTH  events accepted but not yet emitted; registered.
- overflow  output  1  sticky; set when an event was dropped.
- busy  output  1  combinational: (pending != 0) | out_pulse | (gap_cnt != 0).

## Operation
- Counter, per rising edge: let inc = in_pulse & accepted, and dec = issue.
  - pending_next = pending + inc - dec.
  - inc and dec in the same cycle leave pending unchanged.
- Accept rule: in_pulse is accepted unless pending is at all-ones and no issue happens on the same edge. An issue frees one slot, so an in_pulse at full with a simultaneous issue is accepted.
- Drop: an in_pulse that is not accepted sets overflow on that edge and leaves pending unchanged.
- overflow clears on ovf_clr. If a drop and ovf_clr occur on the same edge, set wins.
- Spacer FSM has two states:
  - READY (gap_cnt == 0): if pending != 0, issue. Issue sets out_pulse to 1 for one cycle, loads gap_cnt with GAP-1, and moves to HOLD.
  - HOLD: gap_cnt decrements each edge. When it reaches 0, return to READY.
- out_pulse is 0 in every cycle without an issue. It is never high two consecutive cycles, since GAP ≥ 2.
- Issue decisions use the registered pending value. An in_pulse arriving while pending == 0 is not issued on the same edge.
- Arithmetic:
  - pending never wraps: increment is blocked at all-ones, and decrement happens only when pending ≠ 0.
  - gap_cnt width is 8 bits.
- Reset applies immediately and asynchronously, including mid-operation:
  - out_pulse = 0, pending = 0, overflow = 0, gap_cnt = 0, state = READY.
  - Queued events are discarded.
  - After release, the first in_pulse behaves as if from idle.

## Timing
- Latency from idle: in_pulse high in the cycle before edge k gives pending = 1 after edge k. out_pulse is then high in the cycle after edge k+1, and pending returns to 0 after edge k+1.
- Spacing: if out_pulse is asserted by edge t, the next assertion is no earlier than edge t+GAP. It is exactly t+GAP when pending ≠ 0 at that point.
- Sustained throughput is 1 event per GAP cycles. A burst larger than the capacity plus the events drained during the burst overflows.
- An event is emitted exactly once. Every accepted event appears on out_pulse unless reset intervenes.
- busy is high from the edge after the first accepted in_pulse until gap_cnt returns to 0 with pending == 0.

## Test plan
- Single event, GAP=4: one in_pulse before edge 0 → pending=1 after edge 0; out_pulse high only after edge 1; pending=0; busy low after edge 4.
- Burst, GAP=4, CNT_WIDTH=4: 5 back-to-back in_pulses before edges 0–4 → out_pulse after edges 1, 5, 9, 13, 17; pending peaks at 4; overflow stays 0.
- Saturation, CNT_WIDTH=2, GAP=8: 6 back-to-back in_pulses before edges 0–5.
  - out_pulse after edge 1 (pending 1→0, in_pulse accepted on same edge, stays 1).
  - pending reaches 3 after edge 3.
  - in_pulses before edges 4 and 5 are dropped; overflow=1 after edge 4.
  - Exactly 4 out_pulses follow, at edges 1, 9, 17, 25.
- Simultaneous full and issue: CNT_WIDTH=2, pending=3, state READY, in_pulse on the issue edge → out_pulse=1, pending stays 3, overflow stays 0.
- Overflow clear race: a drop and ovf_clr on the same edge → overflow=1. ovf_clr alone on the next edge → overflow=0.
- Reset mid-operation: pending=3 and in HOLD, assert tx_rst_b low between edges → all outputs 0 immediately. After release, a single in_pulse yields exactly one out_pulse, 2 edges later.

Source files
------------

// File: rtl/pulse_gap_shaper.sv
// Pulse queue and spacer for the TX domain. Counts incoming event pulses and
// re-emits them one at a time, at least GAP cycles apart, ahead of a pulse synchronizer.
module pulse_gap_shaper #(
   parameter int unsigned CNT_WIDTH = 4,
   parameter int unsigned GAP       = 4
) (
   input  logic                 tx_clk,
   input  logic                 tx_rst_b,
   input  logic                 in_pulse,
   input  logic                 ovf_clr,
   output logic                 out_pulse,
   output logic [CNT_WIDTH-1:0] pending,
   output logic                 overflow,
   output logic                 busy
);

   localparam logic [0:0]           StReady = 1'b0;
   localparam logic [0:0]           StHold  = 1'b1;
   localparam logic [7:0]           GapLoad = 8'(GAP - 1);
   localparam logic [CNT_WIDTH-1:0] CntFull = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

   logic [0:0]           state_q, state_d;
   logic [7:0]           gap_q, gap_d;
   logic [CNT_WIDTH-1:0] pend_q, pend_d;
   logic                 ovf_q, ovf_d;
   logic                 out_q, out_d;
   logic                 issue, accept, drop;

   // An issue on this edge frees a slot, so a full counter may still accept.
   always_comb begin
      issue  = (state_q == StReady) && (pend_q != '0);
      accept = in_pulse && ((pend_q != CntFull) || issue);
      drop   = in_pulse && !accept;

      pend_d = pend_q;
      if (accept && !issue) begin
         pend_d = pend_q + CntOne;
      end else if (!accept && issue) begin
         pend_d = pend_q - CntOne;
      end

      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      out_d   = 1'b0;
      case (state_q)
         StReady: begin
            if (issue) begin
               out_d   = 1'b1;
               gap_d   = GapLoad;
               state_d = StHold;
            end
         end
         StHold: begin
            gap_d = gap_q - 8'd1;
            if (gap_q == 8'd1) begin
               state_d = StReady;
            end
         end
         default: state_d = StReady;
      endcase
   end

   always_ff @(posedge tx_clk or negedge tx_rst_b) begin
      if (!tx_rst_b) begin
         state_q <= StReady;
         gap_q   <= 8'd0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         out_q   <= out_d;
      end
   end

   assign out_pulse = out_q;
   assign pending   = pend_q;
   assign overflow  = ovf_q;
   assign busy      = (pend_q != '0) | out_q | (gap_q != 8'd0);

endmodule

// File: tb/tb_pulse_gap_shaper.sv
// Bench for pulse_gap_shaper: two parameterisations driven in parallel and compared
// every cycle against an event-count / last-issue-time reference model.
module tb_pulse_gap_shaper;

   localparam int CW_A = 4, GAP_A = 4;
   localparam int CW_B = 2, GAP_B = 8;

   logic            clk = 1'b0;
   logic            rst_b = 1'b0;
   logic            in_pulse = 1'b0;
   logic            ovf_clr = 1'b0;
   logic            out_a, ovf_a, busy_a;
   logic            out_b, ovf_b, busy_b;
   logic [CW_A-1:0] pending_a;
   logic [CW_B-1:0] pending_b;

   pulse_gap_shaper #(.CNT_WIDTH(CW_A), .GAP(GAP_A)) dut_a (
      .tx_clk(clk), .tx_rst_b(rst_b), .in_pulse(in_pulse), .ovf_clr(ovf_clr),
      .out_pulse(out_a), .pending(pending_a), .overflow(ovf_a), .busy(busy_a)
   );

   pulse_gap_shaper #(.CNT_WIDTH(CW_B), .GAP(GAP_B)) dut_b (
      .tx_clk(clk), .tx_rst_b(rst_b), .in_pulse(in_pulse), .ovf_clr(ovf_clr),
      .out_pulse(out_b), .pending(pending_b), .overflow(ovf_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int edge_no = 0;

   // Reference state: queued event count, edge of last emission, sticky drop flag.
   int pend_ma, last_ma, pend_mb, last_mb;
   bit ovf_ma, ovf_mb, out_ma, out_mb;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_no, obs, exp);
      end
   endtask

   task automatic model_edge(input int cw, input int gap, inout int pend, inout int last,
                             inout bit ovf, output bit out);
      int cap;
      bit issue;
      bit drop;
      cap   = (1 << cw) - 1;
      issue = (pend > 0) && (edge_no - last >= gap);
      drop  = 1'b0;
      if (in_pulse) begin
         if (pend < cap || issue) pend++;
         else drop = 1'b1;
      end
      if (issue) begin
         pend--;
         last = edge_no;
      end
      if (drop) ovf = 1'b1;
      else if (ovf_clr) ovf = 1'b0;
      out = issue;
   endtask

   task automatic model_reset();
      pend_ma = 0; last_ma = -1000; ovf_ma = 1'b0; out_ma = 1'b0;
      pend_mb = 0; last_mb = -1000; ovf_mb = 1'b0; out_mb = 1'b0;
   endtask

   task automatic compare_all();
      check("a_pending", int'(pending_a), pend_ma);
      check("a_out", int'(out_a), int'(out_ma));
      check("a_overflow", int'(ovf_a), int'(ovf_ma));
      check("a_busy", int'(busy_a),
            int'(pend_ma != 0 || out_ma || (edge_no - last_ma <= GAP_A - 2)));
      check("b_pending", int'(pending_b), pend_mb);
      check("b_out", int'(out_b), int'(out_mb));
      check("b_overflow", int'(ovf_b), int'(ovf_mb));
      check("b_busy", int'(busy_b),
            int'(pend_mb != 0 || out_mb || (edge_no - last_mb <= GAP_B - 2)));
   endtask

   task automatic step(input bit ip, input bit oc);
      in_pulse = ip;
      ovf_clr  = oc;
      @(posedge clk);
      model_edge(CW_A, GAP_A, pend_ma, last_ma, ovf_ma, out_ma);
      model_edge(CW_B, GAP_B, pend_mb, last_mb, ovf_mb, out_mb);
      #1;
      compare_all();
      edge_no++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   // Asserted between edges; outputs must clear without waiting for a clock.
   task automatic do_reset();
      in_pulse = 1'b0;
      ovf_clr  = 1'b0;
      rst_b    = 1'b0;
      #2;
      check("rst_a_out", int'(out_a), 0);
      check("rst_a_pending", int'(pending_a), 0);
      check("rst_a_overflow", int'(ovf_a), 0);
      check("rst_a_busy", int'(busy_a), 0);
      check("rst_b_out", int'(out_b), 0);
      check("rst_b_pending", int'(pending_b), 0);
      check("rst_b_overflow", int'(ovf_b), 0);
      check("rst_b_busy", int'(busy_b), 0);
      model_reset();
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   initial begin
      int peak;
      int cnt;
      int density;
      bit ip;
      bit oc;

      model_reset();
      #2;
      check("init_out", int'(out_a), 0);
      check("init_pending", int'(pending_a), 0);
      check("init_busy", int'(busy_b), 0);
      @(negedge clk);
      rst_b = 1'b1;

      // Single event on the GAP=4 instance.
      step(1'b1, 1'b0);
      check("single_pend1", int'(pending_a), 1);
      check("single_no_out", int'(out_a), 0);
      step(1'b0, 1'b0);
      check("single_out", int'(out_a), 1);
      check("single_pend0", int'(pending_a), 0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("single_busy_e3", int'(busy_a), 1);
      step(1'b0, 1'b0);
      check("single_busy_e4", int'(busy_a), 0);
      idle(20);

      // Five back-to-back events.
      step(1'b0, 1'b1);
      peak = 0;
      cnt  = 0;
      for (int i = 0; i < 45; i++) begin
         step(i < 5, 1'b0);
         if (int'(pending_a) > peak) peak = int'(pending_a);
         cnt += int'(out_a);
      end
      check("burst_peak", peak, 4);
      check("burst_count", cnt, 5);
      check("burst_no_ovf", int'(ovf_a), 0);
      step(1'b0, 1'b1);
      idle(10);

      // Saturation, clear race and full-with-issue on the CNT_WIDTH=2 instance.
      cnt = 0;
      step(1'b1, 1'b0); cnt += int'(out_b);
      step(1'b1, 1'b0); cnt += int'(out_b);
      check("sat_out_e1", int'(out_b), 1);
      check("sat_pend_e1", int'(pending_b), 1);
      step(1'b1, 1'b0); cnt += int'(out_b);
      step(1'b1, 1'b0); cnt += int'(out_b);
      check("sat_pend_e3", int'(pending_b), 3);
      check("sat_ovf_e3", int'(ovf_b), 0);
      step(1'b1, 1'b0); cnt += int'(out_b);
      check("sat_ovf_e4", int'(ovf_b), 1);
      check("sat_pend_e4", int'(pending_b), 3);
      step(1'b1, 1'b1); cnt += int'(out_b);
      check("clr_race", int'(ovf_b), 1);
      step(1'b0, 1'b1); cnt += int'(out_b);
      check("clr_alone", int'(ovf_b), 0);
      step(1'b0, 1'b0); cnt += int'(out_b);
      step(1'b0, 1'b0); cnt += int'(out_b);
      step(1'b1, 1'b0); cnt += int'(out_b);
      check("full_issue_out", int'(out_b), 1);
      check("full_issue_pend", int'(pending_b), 3);
      check("full_issue_ovf", int'(ovf_b), 0);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0);
         cnt += int'(out_b);
      end
      check("sat_count", cnt, 5);
      step(1'b0, 1'b1);
      idle(5);

      // Reset while holding with a full queue.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("pre_rst_pend", int'(pending_b), 3);
      do_reset();
      cnt = 0;
      step(1'b1, 1'b0);
      cnt += int'(out_b);
      step(1'b0, 1'b0);
      check("post_rst_out", int'(out_b), 1);
      cnt += int'(out_b);
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b0);
         cnt += int'(out_b);
      end
      check("post_rst_count", cnt, 1);

      // Randomized traffic with varying density and occasional resets.
      density = 5;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) density = int'($urandom_range(1, 10));
         ip = (int'($urandom_range(1, 10)) <= density);
         oc = ($urandom_range(0, 15) == 0);
         step(ip, oc);
         if ($urandom_range(0, 599) == 0) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
